serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - Bin, one bit per clock, LSB first.
// Parallel operands in, parallel difference and borrow out, start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;

  logic d;
  logic br_next;
  logic last;

  // Single full-subtractor cell
  assign d       = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      br   <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sr  <= {d, sr[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= {d, sr[WIDTH-1:1]};
            bout <= br_next;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor at WIDTH=4,
// compared against plain-arithmetic reference results.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_chk = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_diff(int x, int y, int c);
    return (x - y - c + 64) % 16;
  endfunction

  function automatic int ref_bout(int x, int y, int c);
    return (x < y + c) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accept; returns edges taken and busy cycles seen
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input int x, input int y, input int c, input string tag);
    int n, nb;
    a = W'(x); b = W'(y); bin = c[0]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check({tag, "_lat"},  n, W);
    check({tag, "_busy"}, nb, W);
    check({tag, "_diff"}, diff, ref_diff(x, y, c));
    check({tag, "_bout"}, bout, ref_bout(x, y, c));
    tick();
    check({tag, "_pulse"}, done, 0);
  endtask

  int order [512];
  int hd, hb, nd, n, nb, t;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0;
    tick();

    run_op(9, 3, 0, "nom");
    run_op(3, 9, 0, "uf1");
    run_op(0, 0, 1, "uf2");
    run_op(8, 7, 1, "uf3");

    // Exhaustive in shuffled order, start held high for back-to-back runs
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j;
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    a = W'(order[0] >> 5); b = W'(order[0] >> 1); bin = order[0][0];
    start = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      int x, y, c;
      x = (order[i] >> 5) & 15;
      y = (order[i] >> 1) & 15;
      c = order[i] & 1;
      wait_done(n, nb);
      check("ex_lat",  n, W);
      check("ex_diff", diff, ref_diff(x, y, c));
      check("ex_bout", bout, ref_bout(x, y, c));
      if (i < 511) begin
        a = W'(order[i+1] >> 5); b = W'(order[i+1] >> 1); bin = order[i+1][0];
        tick();
        check("ex_acc", busy, 1);
      end
    end
    start = 1'b0;
    tick();
    check("ex_idle", busy, 0);

    for (int i = 0; i < 20; i++)
      run_op($urandom_range(15, 0), $urandom_range(15, 0),
             $urandom_range(1, 0), "rnd");

    // Start ignored while busy
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd1; b = 4'd1; bin = 1'b1; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    nd = 0; hd = 0; hb = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin nd++; hd = diff; hb = bout; end
      tick();
    end
    check("ign_pulses", nd, 1);
    check("ign_diff", hd, 6);
    check("ign_bout", hb, 0);
    check("ign_busy", busy, 0);

    // Reset mid-operation
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_diff", diff, 0);
    check("mid_bout", bout, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) nd++;
      tick();
    end
    check("mid_quiet", nd, 0);
    run_op(15, 15, 1, "post");

    // Result hold
    hd = diff; hb = bout;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_diff", diff, hd);
      check("hold_bout", bout, hb);
      check("hold_done", done, 0);
      check("hold_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
